// File: rtl/spi_pixel_master.sv
// Host-side SPI mode-0 initiator: register write/read, screen reset and pixel streaming frames.
// Optional SPI_MASTER_ECHO_EN: report every MISO byte received while pixel bytes are streamed.
module spi_pixel_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4,
    parameter int GRP_W   = 16
) (
    input  logic             clk_p,
    input  logic             rst_p,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_wdata,
    input  logic [GRP_W-1:0] cmd_len,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [47:0]      pix_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             sck,
    output logic             css,
    output logic             mosi,
    input  logic             miso
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        NEXT     = 3'd3,
        CS_HOLD  = 3'd4,
        CS_GAP   = 3'd5
    } state_t;

    localparam logic [1:0]  OP_WRITE  = 2'd0;
    localparam logic [1:0]  OP_READ   = 2'd1;
    localparam logic [1:0]  OP_SCRST  = 2'd2;
    localparam logic [1:0]  OP_STREAM = 2'd3;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_IDLE - 1);

    state_t             state;
    logic [15:0]        div_cnt;
    logic [2:0]         bit_cnt;
    logic [2:0]         byte_idx;
    logic               in_pix;
    logic               loaded;
    logic [1:0]         op;
    logic [7:0]         addr;
    logic [7:0]         wdata;
    logic [GRP_W-1:0]   grp_cnt;
    logic [6:0]         tx_shift;
    logic [6:0]         rx_shift;
    logic [39:0]        pix_buf;
    logic               rx_en;
    logic [7:0]         next_hdr;

    // Header byte for a given frame position (0..2) of each command type.
    function automatic logic [7:0] hdr_byte(input logic [1:0] o, input logic [2:0] idx,
                                            input logic [7:0] a, input logic [7:0] d);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0: begin
                case (o)
                    OP_WRITE:  b = 8'h80;
                    OP_READ:   b = 8'h81;
                    OP_SCRST:  b = {7'b0100000, a[0]};
                    OP_STREAM: b = 8'h55;
                    default:   b = 8'h00;
                endcase
            end
            3'd1:    b = (o == OP_WRITE || o == OP_READ) ? a : 8'h00;
            3'd2:    b = (o == OP_WRITE) ? d : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef SPI_MASTER_ECHO_EN
    assign rx_en = in_pix || (op == OP_READ && byte_idx == 3'd2);
`else
    assign rx_en = !in_pix && op == OP_READ && byte_idx == 3'd2;
`endif

    assign next_hdr = hdr_byte(op, byte_idx, addr, wdata);

    // Frame sequencer: owns css/sck/mosi timing, byte selection and MISO capture.
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state     <= IDLE;
            div_cnt   <= 16'd0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 3'd0;
            in_pix    <= 1'b0;
            loaded    <= 1'b0;
            op        <= 2'd0;
            addr      <= 8'h00;
            wdata     <= 8'h00;
            grp_cnt   <= {GRP_W{1'b0}};
            tx_shift  <= 7'd0;
            rx_shift  <= 7'd0;
            pix_buf   <= 40'd0;
            cmd_ready <= 1'b0;
            pix_ready <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            busy      <= 1'b0;
            sck       <= 1'b0;
            css       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            pix_ready <= 1'b0;
            rx_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    sck <= 1'b0;
                    css <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        op        <= cmd_op;
                        addr      <= cmd_addr;
                        wdata     <= cmd_wdata;
                        grp_cnt   <= cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        css       <= 1'b1;
                        tx_shift  <= hdr_byte(cmd_op, 3'd0, cmd_addr, cmd_wdata) & 8'h7f;
                        mosi      <= hdr_byte(cmd_op, 3'd0, cmd_addr, cmd_wdata) >> 7;
                        div_cnt   <= 16'd0;
                        bit_cnt   <= 3'd0;
                        byte_idx  <= 3'd0;
                        in_pix    <= 1'b0;
                        state     <= CS_SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                CS_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= 16'd0;
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[5:0], miso};
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else if (sck) begin
                        div_cnt <= 16'd0;
                        sck     <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            loaded  <= 1'b0;
                            if (!in_pix) begin
                                if (byte_idx != 3'd2) begin
                                    byte_idx <= byte_idx + 3'd1;
                                    state    <= NEXT;
                                end else if (op == OP_STREAM && grp_cnt != {GRP_W{1'b0}}) begin
                                    in_pix   <= 1'b1;
                                    byte_idx <= 3'd0;
                                    state    <= NEXT;
                                end else begin
                                    mosi  <= 1'b0;
                                    state <= CS_HOLD;
                                end
                            end else if (byte_idx != 3'd5) begin
                                byte_idx <= byte_idx + 3'd1;
                                state    <= NEXT;
                            end else begin
                                grp_cnt  <= grp_cnt - GRP_W'(1);
                                byte_idx <= 3'd0;
                                if (grp_cnt != GRP_W'(1)) begin
                                    state <= NEXT;
                                end else begin
                                    mosi  <= 1'b0;
                                    state <= CS_HOLD;
                                end
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            mosi     <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                        end
                    end else begin
                        div_cnt  <= 16'd0;
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[5:0], miso};
                        if (bit_cnt == 3'd7 && rx_en) begin
                            rx_data  <= {rx_shift, miso};
                            rx_valid <= 1'b1;
                        end else begin
                            rx_valid <= 1'b0;
                        end
                    end
                end
                NEXT: begin
                    // sck stays low here; a new pixel group may stall indefinitely
                    if (!loaded) begin
                        div_cnt <= 16'd0;
                        if (!in_pix) begin
                            tx_shift <= next_hdr[6:0];
                            mosi     <= next_hdr[7];
                            loaded   <= 1'b1;
                        end else if (byte_idx != 3'd0) begin
                            tx_shift <= pix_buf[38:32];
                            mosi     <= pix_buf[39];
                            pix_buf  <= {pix_buf[31:0], 8'h00};
                            loaded   <= 1'b1;
                        end else if (pix_valid) begin
                            tx_shift  <= pix_data[46:40];
                            mosi      <= pix_data[47];
                            pix_buf   <= pix_data[39:0];
                            pix_ready <= 1'b1;
                            loaded    <= 1'b1;
                        end else begin
                            loaded <= 1'b0;
                        end
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt  <= 16'd0;
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[5:0], miso};
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                CS_HOLD: begin
                    sck <= 1'b0;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 16'd0;
                        css     <= 1'b0;
                        state   <= CS_GAP;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                CS_GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt   <= 16'd0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: begin
                    sck   <= 1'b0;
                    css   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
